// File: rtl/ot_receiver_core.sv
// ot_receiver_core -- receiver side of a 1-of-2 oblivious transfer.
//
// Flow: take the sender's public key (N, e) and the two random values x0, x1
// over the inbound byte stream, blind the choice as v = (x_b + k^e) mod N,
// send v back, take the two packed messages m'0, m'1, and recover
// m_b = (m'_b - k) mod N. All words are W bits, moved W/8 bytes LSB first.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start, choice        start pulse (ignored while busy), selection bit b
//   rand_k               blinding value k, sampled on start
//   rx_valid/ready/data  inbound byte stream
//   tx_valid/ready/data  outbound byte stream
//   busy                 high from accepted start until done or error
//   done, error          one-cycle pulses (error: received N < 2)
//   message_out          recovered m_b, held until the next done

// Modular multiply engine: interleaved shift-add, a scanned MSB first,
// r kept below N after every step. go may be issued in the same cycle that
// fin is high, so back-to-back products cost exactly W cycles each.
// Requires b < N.
module ot_modmul #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         go,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] res,
  output logic         fin
);
  localparam int CW = $clog2(W);

  logic          act;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_sh, b_l;

  // One step: r' = (2r + ai*b) mod N. 2r < 2N and r2 + b < 2N, so a single
  // conditional subtract after each add suffices; W+2 bits never overflow.
  function automatic logic [W-1:0] step(input logic [W-1:0] r, input logic ai,
                                        input logic [W-1:0] bb, input logic [W-1:0] nn);
    logic [W+1:0] t, nx;
    nx = {2'b00, nn};
    t  = {1'b0, r, 1'b0};
    if (t >= nx) t = t - nx;
    if (ai) t = t + {2'b00, bb};
    if (t >= nx) t = t - nx;
    return t[W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act  <= 1'b0;
      cnt  <= '0;
      a_sh <= '0;
      b_l  <= '0;
      res  <= '0;
      fin  <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (go) begin
        // First step is done in the launch cycle.
        res  <= step({W{1'b0}}, a[W-1], b, n);
        a_sh <= a << 1;
        b_l  <= b;
        cnt  <= CW'(1);
        act  <= 1'b1;
      end else if (act) begin
        res  <= step(res, a_sh[W-1], b_l, n);
        a_sh <= a_sh << 1;
        cnt  <= cnt + 1'b1;
        if (cnt == CW'(W-1)) begin
          act <= 1'b0;
          fin <= 1'b1;
        end
      end
    end
  end
endmodule

module ot_receiver_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         choice,
  input  logic [W-1:0] rand_k,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic [7:0]   rx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [W-1:0] message_out
);
  localparam int NB    = W / 8;
  localparam int PUB_B = 4 * NB;
  localparam int MSG_B = 2 * NB;
  localparam int BCW   = $clog2(PUB_B);
  localparam int TCW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW    = $clog2(W);

  typedef enum logic [3:0] {
    S_IDLE, S_RX_PUB, S_RED, S_EXP, S_ADD, S_TX_V, S_RX_MSG, S_UNBLIND, S_FIN
  } st_t;

  st_t            st;
  logic           choice_l, kick, ph;
  logic [W-1:0]   k_l, kr, xr, acc, m_res, tx_sh;
  logic [4*W-1:0] pub;      // {x1, x0, e, N}, filled LSB byte first
  logic [2*W-1:0] msg;      // {m'1, m'0}
  logic [BCW-1:0] rx_cnt;
  logic [TCW-1:0] tx_cnt;
  logic [IW-1:0]  bit_idx;

  logic [W-1:0] key_n, key_e, xb, n_next, mb;
  logic [W:0]   v_sum;
  logic         rx_fire, tx_fire;

  logic         mm_go, mm_fin;
  logic [W-1:0] mm_a, mm_b, mm_res;

  assign key_n   = pub[W-1:0];
  assign key_e   = pub[2*W-1:W];
  assign xb      = choice_l ? pub[4*W-1:3*W] : pub[3*W-1:2*W];
  assign n_next  = pub[W+7:8];   // N as it will sit after the current byte shifts in
  assign mb      = choice_l ? msg[2*W-1:W] : msg[W-1:0];
  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;

  always_comb begin
    v_sum = {1'b0, xr} + {1'b0, acc};
    if (v_sum >= {1'b0, key_n}) v_sum = v_sum - {1'b0, key_n};
  end

  // Launch decisions for the multiplier. Next operands come straight from
  // mm_res so a new product starts in the cycle the previous one finishes.
  always_comb begin
    mm_go = 1'b0;
    mm_a  = acc;
    mm_b  = acc;
    case (st)
      S_RED: begin
        if (kick) begin
          mm_go = 1'b1; mm_a = k_l; mm_b = W'(1);
        end else if (mm_fin && !ph) begin
          mm_go = 1'b1; mm_a = xb;  mm_b = W'(1);
        end else if (mm_fin && ph) begin
          // first square of the exponentiation: acc = 1
          mm_go = 1'b1; mm_a = W'(1); mm_b = W'(1);
        end
      end
      S_EXP: begin
        if (mm_fin) begin
          if (!ph && key_e[bit_idx]) begin
            mm_go = 1'b1; mm_a = mm_res; mm_b = kr;
          end else if (bit_idx != '0) begin
            mm_go = 1'b1; mm_a = mm_res; mm_b = mm_res;
          end
        end
      end
      default: ;
    endcase
  end

  ot_modmul #(.W(W)) u_mm (
    .clk(clk), .rstn(rstn), .go(mm_go), .a(mm_a), .b(mm_b), .n(key_n),
    .res(mm_res), .fin(mm_fin)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st          <= S_IDLE;
      choice_l    <= 1'b0;
      kick        <= 1'b0;
      ph          <= 1'b0;
      k_l         <= '0;
      kr          <= '0;
      xr          <= '0;
      acc         <= '0;
      m_res       <= '0;
      tx_sh       <= '0;
      pub         <= '0;
      msg         <= '0;
      rx_cnt      <= '0;
      tx_cnt      <= '0;
      bit_idx     <= '0;
      rx_ready    <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      message_out <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (st)
        S_IDLE: begin
          // done is high in the first IDLE cycle; a start there is dropped
          if (start && !done) begin
            choice_l <= choice;
            k_l      <= rand_k;
            busy     <= 1'b1;
            rx_ready <= 1'b1;
            rx_cnt   <= '0;
            st       <= S_RX_PUB;
          end
        end
        S_RX_PUB: begin
          if (rx_fire) begin
            pub    <= {rx_data, pub[4*W-1:8]};
            rx_cnt <= rx_cnt + 1'b1;
            if (rx_cnt == BCW'(PUB_B-1)) begin
              rx_ready <= 1'b0;
              if (n_next[W-1:1] == '0) begin
                error <= 1'b1;
                busy  <= 1'b0;
                st    <= S_IDLE;
              end else begin
                kick <= 1'b1;
                ph   <= 1'b0;
                st   <= S_RED;
              end
            end
          end
        end
        S_RED: begin
          if (kick) begin
            kick <= 1'b0;
          end else if (mm_fin && !ph) begin
            kr <= mm_res;
            ph <= 1'b1;
          end else if (mm_fin && ph) begin
            xr      <= mm_res;
            acc     <= W'(1);
            ph      <= 1'b0;
            bit_idx <= IW'(W-1);
            st      <= S_EXP;
          end
        end
        S_EXP: begin
          // ph=0: a square just finished; ph=1: a multiply by kr finished
          if (mm_fin) begin
            acc <= mm_res;
            if (!ph && key_e[bit_idx]) begin
              ph <= 1'b1;
            end else begin
              ph <= 1'b0;
              if (bit_idx == '0) st <= S_ADD;
              else bit_idx <= bit_idx - 1'b1;
            end
          end
        end
        S_ADD: begin
          tx_data  <= v_sum[7:0];
          tx_sh    <= v_sum[W-1:0] >> 8;
          tx_valid <= 1'b1;
          tx_cnt   <= '0;
          st       <= S_TX_V;
        end
        S_TX_V: begin
          if (tx_fire) begin
            if (tx_cnt == TCW'(NB-1)) begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              rx_cnt   <= '0;
              st       <= S_RX_MSG;
            end else begin
              tx_cnt  <= tx_cnt + 1'b1;
              tx_data <= tx_sh[7:0];
              tx_sh   <= tx_sh >> 8;
            end
          end
        end
        S_RX_MSG: begin
          if (rx_fire) begin
            msg    <= {rx_data, msg[2*W-1:8]};
            rx_cnt <= rx_cnt + 1'b1;
            if (rx_cnt == BCW'(MSG_B-1)) begin
              rx_ready <= 1'b0;
              st       <= S_UNBLIND;
            end
          end
        end
        S_UNBLIND: begin
          // m'_b < N is trusted; the wrapped difference lands back in [0, N)
          m_res <= (mb >= kr) ? (mb - kr) : (mb - kr + key_n);
          st    <= S_FIN;
        end
        S_FIN: begin
          message_out <= m_res;
          done        <= 1'b1;
          busy        <= 1'b0;
          st          <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule
